dplca_txop_table_manager: RTL and testbench

- Owns the D-PLCA TXOP claim table: 256 entries × 2-bit age.
- Records claims observed on the medium and ages the table once per aging period, counted in PLCA beacon cycles.
- Produces dplca_txop_table_upd, dplca_new_age and table summaries.
- The D-PLCA control state machine and its CLAIMING/MAX_CLAIM/PICK_FREE_TXOP functions consume these outputs.
- Sequences the table resource: serialises claim writes against the multi-cycle aging scan via a valid/ready handshake.

---
 rtl/dplca_claim_if.sv | 9 +
 rtl/dplca_txop_table_manager.sv | 187 ++++++++++++++++++
 tb/tb_dplca_txop_table_manager.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dplca_claim_if.sv
// Claim handshake between the D-PLCA claim source and the TXOP table manager.
interface dplca_claim_if;
    logic       claim_valid;
    logic [7:0] claim_id;
    logic       claim_ready;

    modport master (output claim_valid, output claim_id, input claim_ready);
    modport slave  (input claim_valid, input claim_id, output claim_ready);
endinterface

// File: rtl/dplca_txop_table_manager.sv
// D-PLCA TXOP claim table: records claims, ages every AGE_CYCLES beacons with a
// multi-cycle scan, and publishes the table plus max/count summaries.
module dplca_txop_table_manager #(
    parameter int AGE_CYCLES = 16,
    parameter int MAX_AGE    = 3,
    parameter int SCAN_WIDTH = 4
) (
    input  logic               clk,
    input  logic               plca_reset,
    input  logic               dplca_aging,
    input  logic               beacon_seen,
    dplca_claim_if.slave       claim,
    output logic [511:0]       txop_claim_table_unpacked,
    output logic               dplca_txop_table_upd,
    output logic               dplca_new_age,
    output logic [7:0]         max_claim,
    output logic [8:0]         claim_count,
    output logic               aging_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int              CNT_W     = (AGE_CYCLES > 1) ? $clog2(AGE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(AGE_CYCLES - 1);
    localparam logic [7:0]      LAST_PTR  = 8'(256 - SCAN_WIDTH);
    localparam logic [7:0]      PTR_STEP  = 8'(SCAN_WIDTH);
    localparam logic [1:0]      CLAIM_AGE = 2'(MAX_AGE);

    state_t             state_q, state_d;
    logic [511:0]       table_q, table_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         ptr_q, ptr_d;
    logic               upd_q, upd_d;
    logic               new_age_q, new_age_d;
    logic [7:0]         max_q, max_d;
    logic [8:0]         count_q, count_d;
    logic [7:0]         shadow_max_q, shadow_max_d;
    logic [8:0]         shadow_cnt_q, shadow_cnt_d;
    logic               pending_upd_q, pending_upd_d;
    logic               clear_s;
    logic [7:0]         idx_s;
    logic [1:0]         age_s;

    // Beacon counter step; a wrap in SCAN/DONE silently skips that aging period.
    function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] c);
        return (c == LAST_CNT) ? '0 : c + CNT_W'(1);
    endfunction

    assign clear_s                   = plca_reset || !dplca_aging;
    assign claim.claim_ready         = (state_q == ST_IDLE) && !clear_s;
    assign txop_claim_table_unpacked = table_q;
    assign dplca_txop_table_upd      = upd_q;
    assign dplca_new_age             = new_age_q;
    assign max_claim                 = max_q;
    assign claim_count               = count_q;
    assign aging_busy                = (state_q == ST_SCAN);

    // Next-state logic for the FSM, table, counters and summaries.
    always_comb begin
        state_d       = state_q;
        table_d       = table_q;
        cnt_d         = cnt_q;
        ptr_d         = ptr_q;
        upd_d         = 1'b0;
        new_age_d     = new_age_q;
        max_d         = max_q;
        count_d       = count_q;
        shadow_max_d  = shadow_max_q;
        shadow_cnt_d  = shadow_cnt_q;
        pending_upd_d = pending_upd_q;
        idx_s         = 8'd0;
        age_s         = 2'd0;
        if (clear_s) begin
            state_d       = ST_IDLE;
            table_d       = '0;
            cnt_d         = '0;
            ptr_d         = 8'd0;
            new_age_d     = 1'b0;
            max_d         = 8'd0;
            count_d       = 9'd0;
            shadow_max_d  = 8'd0;
            shadow_cnt_d  = 9'd0;
            pending_upd_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // The claim lands before a same-cycle scan starts, so the scan ages it.
                    if (claim.claim_valid) begin
                        table_d[{claim.claim_id, 1'b0} +: 2] = CLAIM_AGE;
                    end else begin
                        table_d = table_q;
                    end
                    if (beacon_seen && (cnt_q == LAST_CNT)) begin
                        cnt_d        = '0;
                        state_d      = ST_SCAN;
                        ptr_d        = 8'd0;
                        shadow_max_d = 8'd0;
                        shadow_cnt_d = 9'd0;
                    end else if (beacon_seen) begin
                        cnt_d     = cnt_q + CNT_W'(1);
                        upd_d     = 1'b1;
                        new_age_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_SCAN: begin
                    // Ascending scan: the last surviving index seen is the table maximum.
                    for (int i = 0; i < SCAN_WIDTH; i++) begin
                        idx_s = ptr_q + 8'(i);
                        age_s = table_q[{idx_s, 1'b0} +: 2];
                        age_s = (age_s != 2'd0) ? age_s - 2'd1 : 2'd0;
                        table_d[{idx_s, 1'b0} +: 2] = age_s;
                        if (age_s != 2'd0) begin
                            shadow_cnt_d = shadow_cnt_d + 9'd1;
                            shadow_max_d = idx_s;
                        end else begin
                            shadow_cnt_d = shadow_cnt_d;
                        end
                    end
                    if (ptr_q == LAST_PTR) begin
                        ptr_d   = 8'd0;
                        state_d = ST_DONE;
                    end else begin
                        ptr_d = ptr_q + PTR_STEP;
                    end
                    if (beacon_seen) begin
                        cnt_d         = next_cnt(cnt_q);
                        pending_upd_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_DONE: begin
                    max_d         = shadow_max_q;
                    count_d       = shadow_cnt_q;
                    upd_d         = 1'b1;
                    new_age_d     = 1'b1;
                    pending_upd_d = 1'b0;
                    state_d       = ST_IDLE;
                    if (beacon_seen) begin
                        cnt_d = next_cnt(cnt_q);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (plca_reset) begin
            state_q       <= ST_IDLE;
            table_q       <= '0;
            cnt_q         <= '0;
            ptr_q         <= 8'd0;
            upd_q         <= 1'b0;
            new_age_q     <= 1'b0;
            max_q         <= 8'd0;
            count_q       <= 9'd0;
            shadow_max_q  <= 8'd0;
            shadow_cnt_q  <= 9'd0;
            pending_upd_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            table_q       <= table_d;
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            upd_q         <= upd_d;
            new_age_q     <= new_age_d;
            max_q         <= max_d;
            count_q       <= count_d;
            shadow_max_q  <= shadow_max_d;
            shadow_cnt_q  <= shadow_cnt_d;
            pending_upd_q <= pending_upd_d;
        end
    end

endmodule

// File: tb/tb_dplca_txop_table_manager.sv
// Self-checking bench for dplca_txop_table_manager against an array-based table model.
module tb_dplca_txop_table_manager;

    logic         clk = 1'b0;
    logic         plca_reset;
    logic         dplca_aging;
    logic         beacon_seen;
    logic [511:0] tbl;
    logic         upd;
    logic         new_age;
    logic [7:0]   max_claim;
    logic [8:0]   claim_count;
    logic         busy;

    dplca_claim_if cif ();

    dplca_txop_table_manager dut (
        .clk                       (clk),
        .plca_reset                (plca_reset),
        .dplca_aging               (dplca_aging),
        .beacon_seen               (beacon_seen),
        .claim                     (cif),
        .txop_claim_table_unpacked (tbl),
        .dplca_txop_table_upd      (upd),
        .dplca_new_age             (new_age),
        .max_claim                 (max_claim),
        .claim_count               (claim_count),
        .aging_busy                (busy)
    );

    always #5 clk = ~clk;

    // Reference model: plain per-entry ages and a beacon count.
    int   mdl_age [256];
    int   mdl_cnt;
    int   mdl_max;
    int   mdl_count;
    logic mdl_new_age;
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [511:0] mdl_table();
        logic [511:0] t;
        t = '0;
        for (int i = 0; i < 256; i++) t[2*i +: 2] = 2'(mdl_age[i]);
        return t;
    endfunction

    function automatic void mdl_clear();
        for (int i = 0; i < 256; i++) mdl_age[i] = 0;
        mdl_cnt = 0; mdl_max = 0; mdl_count = 0; mdl_new_age = 1'b0;
    endfunction

    function automatic void mdl_claim(int id);
        mdl_age[id] = 3;
    endfunction

    // Returns 1 when this beacon starts an aging scan (only possible from idle).
    function automatic bit mdl_beacon(bit idle);
        mdl_cnt = mdl_cnt + 1;
        if (mdl_cnt == 16) begin
            mdl_cnt = 0;
            return idle;
        end
        return 1'b0;
    endfunction

    function automatic void mdl_age_all();
        mdl_max = 0; mdl_count = 0;
        for (int i = 0; i < 256; i++) begin
            if (mdl_age[i] > 0) mdl_age[i] = mdl_age[i] - 1;
            if (mdl_age[i] > 0) begin mdl_max = i; mdl_count = mdl_count + 1; end
        end
        mdl_new_age = 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        plca_reset = 1'b1; dplca_aging = 1'b1; beacon_seen = 1'b0; cif.claim_valid = 1'b0; cif.claim_id = 8'd0;
        tick(); tick();
        plca_reset = 1'b0;
        mdl_clear();
    endtask

    task automatic pulse_beacon();
        beacon_seen = 1'b1;
        tick();
        beacon_seen = 1'b0;
    endtask

    task automatic claim_one(input int id);
        cif.claim_valid = 1'b1; cif.claim_id = 8'(id);
        tick();
        cif.claim_valid = 1'b0;
        mdl_claim(id);
    endtask

    // Follows a scan from the cycle after the aging beacon until the upd pulse (k = 1 is that first cycle).
    task automatic wait_scan(input int beacon_at, input int claim_at, input int claim_id_in,
                             output int busy_n, output int upd_idx, output int ready_n);
        busy_n = 0; upd_idx = -1; ready_n = 0;
        for (int k = 1; k <= 100; k++) begin
            if (upd) begin upd_idx = k; break; end
            busy_n += int'(busy);
            if (cif.claim_valid && cif.claim_ready) ready_n++;
            if (k == beacon_at) beacon_seen = 1'b1;
            if (k == claim_at) begin cif.claim_valid = 1'b1; cif.claim_id = 8'(claim_id_in); end
            tick();
            beacon_seen = 1'b0;
        end
    endtask

    task automatic test_reset();
        plca_reset = 1'b1; dplca_aging = 1'b1; beacon_seen = 1'b0; cif.claim_valid = 1'b0; cif.claim_id = 8'd0;
        #1;
        n_checks++; if (cif.claim_ready !== 1'b0) $display("FAIL reset_ready_pre: got %b want 0", cif.claim_ready); else n_pass++;
        tick();
        n_checks++; if (cif.claim_ready !== 1'b0) $display("FAIL reset_ready_hold: got %b want 0", cif.claim_ready); else n_pass++;
        tick();
        plca_reset = 1'b0;
        mdl_clear();
        #1;
        n_checks++; if (tbl !== mdl_table()) $display("FAIL reset_table: got %h want %h", tbl, mdl_table()); else n_pass++;
        n_checks++; if (cif.claim_ready !== 1'b1) $display("FAIL reset_ready_after: got %b want 1", cif.claim_ready); else n_pass++;
        n_checks++; if ({upd, new_age, busy} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {upd, new_age, busy}); else n_pass++;
        n_checks++; if ({max_claim, claim_count} !== 17'd0) $display("FAIL reset_summary: got %0d/%0d want 0/0", max_claim, claim_count); else n_pass++;
    endtask

    task automatic test_claim_beacon();
        claim_one(5);
        n_checks++; if (tbl !== mdl_table()) $display("FAIL claim_table: got %h want %h", tbl, mdl_table()); else n_pass++;
        void'(mdl_beacon(1'b1));
        n_checks++; if (upd !== 1'b0) $display("FAIL claim_no_upd: got %b want 0", upd); else n_pass++;
        pulse_beacon();
        n_checks++; if (upd !== 1'b1) $display("FAIL beacon_upd: got %b want 1", upd); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL beacon_busy: got %b want 0", busy); else n_pass++;
        tick();
        n_checks++; if (upd !== 1'b0) $display("FAIL beacon_upd_once: got %b want 0", upd); else n_pass++;
        n_checks++; if (tbl[11:10] !== 2'd3) $display("FAIL entry5_age: got %0d want 3", tbl[11:10]); else n_pass++;
    endtask

    task automatic test_aging();
        int busy_n, upd_idx, ready_n;
        do_reset();
        claim_one(5);
        claim_one(200);
        for (int b = 0; b < 15; b++) begin
            void'(mdl_beacon(1'b1));
            pulse_beacon();
            n_checks++; if (upd !== 1'b1) $display("FAIL aging_plain_upd: beacon %0d got %b want 1", b, upd); else n_pass++;
        end
        n_checks++; if (new_age !== 1'b0) $display("FAIL aging_new_age_pre: got %b want 0", new_age); else n_pass++;
        n_checks++; if (mdl_beacon(1'b1) !== 1'b1) $display("FAIL aging_model_wrap: got 0 want 1"); else n_pass++;
        pulse_beacon();
        wait_scan(0, 0, 0, busy_n, upd_idx, ready_n);
        mdl_age_all();
        n_checks++; if (busy_n !== 64) $display("FAIL aging_busy_len: got %0d want 64", busy_n); else n_pass++;
        n_checks++; if (upd_idx !== 66) $display("FAIL aging_upd_latency: got %0d want 66", upd_idx); else n_pass++;
        n_checks++; if (new_age !== 1'b1) $display("FAIL aging_new_age: got %b want 1", new_age); else n_pass++;
        n_checks++; if (tbl !== mdl_table()) $display("FAIL aging_table: got %h want %h", tbl, mdl_table()); else n_pass++;
        n_checks++; if (max_claim !== 8'(mdl_max)) $display("FAIL aging_max: got %0d want %0d", max_claim, mdl_max); else n_pass++;
        n_checks++; if (claim_count !== 9'(mdl_count)) $display("FAIL aging_count: got %0d want %0d", claim_count, mdl_count); else n_pass++;
    endtask

    task automatic test_expiry();
        int busy_n, upd_idx, ready_n;
        for (int b = 0; b < 48; b++) begin
            if (mdl_beacon(1'b1)) begin
                pulse_beacon();
                wait_scan(0, 0, 0, busy_n, upd_idx, ready_n);
                mdl_age_all();
                n_checks++; if (upd_idx !== 66) $display("FAIL expiry_upd_latency: got %0d want 66", upd_idx); else n_pass++;
                n_checks++; if (tbl !== mdl_table()) $display("FAIL expiry_table: got %h want %h", tbl, mdl_table()); else n_pass++;
                n_checks++; if (max_claim !== 8'(mdl_max)) $display("FAIL expiry_max: got %0d want %0d", max_claim, mdl_max); else n_pass++;
                n_checks++; if (claim_count !== 9'(mdl_count)) $display("FAIL expiry_count: got %0d want %0d", claim_count, mdl_count); else n_pass++;
            end else begin
                pulse_beacon();
                mdl_new_age = 1'b0;
                n_checks++; if (upd !== 1'b1) $display("FAIL expiry_plain_upd: got %b want 1", upd); else n_pass++;
            end
        end
        n_checks++; if ({max_claim, claim_count} !== 17'd0) $display("FAIL expiry_final: got %0d/%0d want 0/0", max_claim, claim_count); else n_pass++;
        n_checks++; if (new_age !== 1'b1) $display("FAIL expiry_new_age_hold: got %b want 1", new_age); else n_pass++;
        void'(mdl_beacon(1'b1));
        pulse_beacon();
        n_checks++; if (new_age !== 1'b0) $display("FAIL expiry_new_age_drop: got %b want 0", new_age); else n_pass++;
    endtask

    task automatic test_stall();
        int busy_n, upd_idx, ready_n, extra;
        do_reset();
        for (int i = 0; i < 6; i++) claim_one(int'($urandom_range(0, 255)));
        claim_one(7);
        for (int b = 0; b < 15; b++) begin void'(mdl_beacon(1'b1)); pulse_beacon(); end
        void'(mdl_beacon(1'b1));
        pulse_beacon();
        wait_scan(20, 10, 7, busy_n, upd_idx, ready_n);
        void'(mdl_beacon(1'b0));
        mdl_age_all();
        n_checks++; if (ready_n !== 0) $display("FAIL stall_ready_during_scan: got %0d want 0", ready_n); else n_pass++;
        n_checks++; if (upd_idx !== 66) $display("FAIL stall_upd_latency: got %0d want 66", upd_idx); else n_pass++;
        n_checks++; if (cif.claim_ready !== 1'b1) $display("FAIL stall_ready_after: got %b want 1", cif.claim_ready); else n_pass++;
        n_checks++; if (tbl !== mdl_table()) $display("FAIL stall_aged_table: got %h want %h", tbl, mdl_table()); else n_pass++;
        tick();
        cif.claim_valid = 1'b0;
        mdl_claim(7);
        extra = 0;
        for (int k = 0; k < 5; k++) begin extra += int'(upd); tick(); end
        n_checks++; if (extra !== 0) $display("FAIL stall_single_upd: got %0d extra pulses want 0", extra); else n_pass++;
        n_checks++; if (tbl !== mdl_table()) $display("FAIL stall_entry7: got %h want %h", tbl, mdl_table()); else n_pass++;
        n_checks++; if (claim_count !== 9'(mdl_count)) $display("FAIL stall_count: got %0d want %0d", claim_count, mdl_count); else n_pass++;
    endtask

    task automatic test_disable();
        for (int b = 0; b < 16; b++) begin
            if (mdl_beacon(1'b1)) break;
            pulse_beacon();
        end
        pulse_beacon();
        for (int k = 1; k < 30; k++) tick();
        n_checks++; if (busy !== 1'b1) $display("FAIL disable_in_scan: got %b want 1", busy); else n_pass++;
        dplca_aging = 1'b0;
        #1;
        n_checks++; if (cif.claim_ready !== 1'b0) $display("FAIL disable_ready: got %b want 0", cif.claim_ready); else n_pass++;
        tick();
        mdl_clear();
        n_checks++; if (tbl !== mdl_table()) $display("FAIL disable_table: got %h want %h", tbl, mdl_table()); else n_pass++;
        n_checks++; if ({busy, upd, new_age} !== 3'b000) $display("FAIL disable_flags: got %b want 000", {busy, upd, new_age}); else n_pass++;
        n_checks++; if ({max_claim, claim_count} !== 17'd0) $display("FAIL disable_summary: got %0d/%0d want 0/0", max_claim, claim_count); else n_pass++;
        dplca_aging = 1'b1;
        tick();
        n_checks++; if (upd !== 1'b0) $display("FAIL disable_no_late_upd: got %b want 0", upd); else n_pass++;
    endtask

    task automatic test_random();
        int busy_n, upd_idx, ready_n, id;
        bit do_claim, do_beacon, aging;
        do_reset();
        for (int it = 0; it < 90; it++) begin
            do_claim  = 1'($urandom_range(0, 1));
            do_beacon = ($urandom_range(0, 2) != 0);
            id        = int'($urandom_range(0, 255));
            cif.claim_valid = do_claim; cif.claim_id = 8'(id); beacon_seen = do_beacon;
            #1;
            n_checks++; if (cif.claim_ready !== 1'b1) $display("FAIL rand_ready: it %0d got %b want 1", it, cif.claim_ready); else n_pass++;
            if (do_claim) mdl_claim(id);
            aging = do_beacon ? mdl_beacon(1'b1) : 1'b0;
            tick();
            cif.claim_valid = 1'b0; beacon_seen = 1'b0;
            if (aging) begin
                wait_scan(0, 0, 0, busy_n, upd_idx, ready_n);
                mdl_age_all();
                n_checks++; if (upd_idx !== 66) $display("FAIL rand_upd_latency: got %0d want 66", upd_idx); else n_pass++;
                n_checks++; if (max_claim !== 8'(mdl_max)) $display("FAIL rand_max: got %0d want %0d", max_claim, mdl_max); else n_pass++;
                n_checks++; if (claim_count !== 9'(mdl_count)) $display("FAIL rand_count: got %0d want %0d", claim_count, mdl_count); else n_pass++;
            end else begin
                if (do_beacon) mdl_new_age = 1'b0;
                n_checks++; if (upd !== do_beacon) $display("FAIL rand_upd: it %0d got %b want %b", it, upd, do_beacon); else n_pass++;
            end
            n_checks++; if (new_age !== mdl_new_age) $display("FAIL rand_new_age: it %0d got %b want %b", it, new_age, mdl_new_age); else n_pass++;
            n_checks++; if (tbl !== mdl_table()) $display("FAIL rand_table: it %0d got %h want %h", it, tbl, mdl_table()); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_claim_beacon();
        test_aging();
        test_expiry();
        test_stall();
        test_disable();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
